// File: rtl/tx_mix_ctrl_if.sv
// Baseband, keying and NCO signals between the TX control/baseband side and tx_mix_ctrl.
interface tx_mix_ctrl_if;
  logic               ptt_req;
  logic [31:0]        freq_in;
  logic               freq_load;
  logic               in_valid;
  logic signed [17:0] i_in;
  logic signed [17:0] q_in;
  logic [31:0]        phi;
  logic signed [17:0] i_sig;
  logic signed [17:0] q_sig;
  logic               tx_on;
  logic               ramp_busy;
  logic [2:0]         state;

  modport master (
    output ptt_req, freq_in, freq_load, in_valid, i_in, q_in,
    input  phi, i_sig, q_sig, tx_on, ramp_busy, state
  );

  modport slave (
    input  ptt_req, freq_in, freq_load, in_valid, i_in, q_in,
    output phi, i_sig, q_sig, tx_on, ramp_busy, state
  );
endinterface

// File: rtl/tx_mix_ctrl.sv
// TX mixer sequencer: free-running NCO, click-free I/Q amplitude ramp, guarded PA keying
// and frequency changes deferred until no ramp is in progress.
module tx_mix_ctrl #(
  parameter int RAMP_SHIFT = 8,
  parameter int KEY_DLY    = 1024,
  parameter int MIX_LAT    = 6,
  parameter int CNT_W      = 16
) (
  input  logic         clk,
  input  logic         rst,
  tx_mix_ctrl_if.slave bus
);
  localparam int GW = RAMP_SHIFT + 1;
  localparam int PW = 18 + GW + 1;
  localparam logic [GW-1:0]    GAIN_FULL = {1'b1, {RAMP_SHIFT{1'b0}}};
  localparam logic [GW-1:0]    GAIN_ZERO = {GW{1'b0}};
  localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_DLY - 1);
  localparam logic [CNT_W-1:0] MIX_LAST  = CNT_W'(MIX_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEYUP  = 3'd1,
    S_RAMPUP = 3'd2,
    S_ON     = 3'd3,
    S_RAMPDN = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [GW-1:0]      r_gain, w_gain_nxt;
  logic [31:0]        r_phi, r_act_inc, r_pend_inc;
  logic               r_pend_flag;
  logic signed [17:0] r_i, r_q;
  logic               w_busy, w_rf_live, w_apply;
  logic signed [PW-1:0] w_prod_i, w_prod_q;
  logic signed [17:0]   w_i_scaled, w_q_scaled;

  assign w_busy    = (r_state == S_RAMPUP) || (r_state == S_RAMPDN);
  assign w_rf_live = w_busy || (r_state == S_ON);
  assign w_apply   = r_pend_flag && !w_busy;

  // Gain is zero-extended so the multiply stays signed; the shift truncates toward -inf.
  assign w_prod_i   = bus.i_in * $signed({1'b0, r_gain});
  assign w_prod_q   = bus.q_in * $signed({1'b0, r_gain});
  assign w_i_scaled = 18'(w_prod_i >>> RAMP_SHIFT);
  assign w_q_scaled = 18'(w_prod_q >>> RAMP_SHIFT);

  // Next state, ramp gain and delay counter.
  always_comb begin
    w_state_nxt = r_state;
    w_gain_nxt  = r_gain;
    case (r_state)
      S_IDLE: begin
        w_gain_nxt = GAIN_ZERO;
        if (bus.ptt_req) w_state_nxt = S_KEYUP;
        else             w_state_nxt = S_IDLE;
      end
      S_KEYUP: begin
        w_gain_nxt = GAIN_ZERO;
        if (!bus.ptt_req)          w_state_nxt = S_DRAIN;
        else if (r_cnt == KEY_LAST) w_state_nxt = S_RAMPUP;
        else                       w_state_nxt = S_KEYUP;
      end
      S_RAMPUP: begin
        if (!bus.ptt_req)            w_state_nxt = S_RAMPDN;
        else if (r_gain == GAIN_FULL) w_state_nxt = S_ON;
        else                         w_state_nxt = S_RAMPUP;
        if (bus.in_valid && (r_gain != GAIN_FULL)) w_gain_nxt = r_gain + GW'(1);
        else                                       w_gain_nxt = r_gain;
      end
      S_ON: begin
        w_gain_nxt = GAIN_FULL;
        if (!bus.ptt_req) w_state_nxt = S_RAMPDN;
        else              w_state_nxt = S_ON;
      end
      S_RAMPDN: begin
        if (bus.ptt_req)              w_state_nxt = S_RAMPUP;
        else if (r_gain == GAIN_ZERO) w_state_nxt = S_DRAIN;
        else                          w_state_nxt = S_RAMPDN;
        if (bus.in_valid && (r_gain != GAIN_ZERO)) w_gain_nxt = r_gain - GW'(1);
        else                                       w_gain_nxt = r_gain;
      end
      S_DRAIN: begin
        w_gain_nxt = GAIN_ZERO;
        if (r_cnt == MIX_LAST) w_state_nxt = S_IDLE;
        else                   w_state_nxt = S_DRAIN;
      end
      default: begin
        w_gain_nxt  = GAIN_ZERO;
        w_state_nxt = S_IDLE;
      end
    endcase
    // The counter restarts on every state change, so each delay state starts from zero.
    if ((w_state_nxt == r_state) && ((r_state == S_KEYUP) || (r_state == S_DRAIN)))
      w_cnt_nxt = r_cnt + CNT_W'(1);
    else
      w_cnt_nxt = {CNT_W{1'b0}};
  end

  // State, NCO, frequency hand-over and sample registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_gain      <= GAIN_ZERO;
      r_phi       <= 32'd0;
      r_act_inc   <= 32'd0;
      r_pend_inc  <= 32'd0;
      r_pend_flag <= 1'b0;
      r_i         <= 18'sd0;
      r_q         <= 18'sd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gain  <= w_gain_nxt;
      r_phi   <= r_phi + r_act_inc;
      if (w_apply) r_act_inc <= r_pend_inc;
      else         r_act_inc <= r_act_inc;
      if (bus.freq_load) begin
        r_pend_inc  <= bus.freq_in;
        r_pend_flag <= 1'b1;
      end else if (w_apply) begin
        r_pend_flag <= 1'b0;
      end else begin
        r_pend_flag <= r_pend_flag;
      end
      if (!w_rf_live) begin
        r_i <= 18'sd0;
        r_q <= 18'sd0;
      end else if (bus.in_valid) begin
        r_i <= w_i_scaled;
        r_q <= w_q_scaled;
      end else begin
        r_i <= r_i;
        r_q <= r_q;
      end
    end
  end

  assign bus.phi       = r_phi;
  assign bus.i_sig     = r_i;
  assign bus.q_sig     = r_q;
  assign bus.tx_on     = (r_state != S_IDLE);
  assign bus.ramp_busy = w_busy;
  assign bus.state     = r_state;
endmodule
